// File: rtl/conversor_bcd_pkg.sv
// -----------------------------------------------------------------------------
// conversor_bcd_pkg
//
// Shared definitions for the signed-binary to two-digit BCD converter:
//   - estado_t       : FSM state encoding (OCIOSO, CONVERTE, FIM)
//   - DIGITO_TRACO   : display code for a dash (overflow indication)
//   - DIGITO_APAGADO : display code for a blank digit
//   - LIMITE_DISPLAY : largest magnitude the two-digit display can show
//   - modulo_de()    : absolute value of an 8-bit two's-complement number
//
// Optional feature macro used by the converter: CONVERSOR_BCD_ZERO_BLANK_EN
// -----------------------------------------------------------------------------
package conversor_bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    localparam logic [3:0] DIGITO_TRACO   = 4'hF;
    localparam logic [3:0] DIGITO_APAGADO = 4'hA;
    localparam logic [7:0] LIMITE_DISPLAY = 8'd99;

    // Number of double-dabble iterations: one per low magnitude bit.
    localparam int unsigned N_ITERACOES = 7;

    // Absolute value as an 8-bit unsigned quantity. -128 maps to 128,
    // which still fits in 8 unsigned bits.
    function automatic logic [7:0] modulo_de(input logic [7:0] valor);
        modulo_de = valor[7] ? (~valor + 8'd1) : valor;
    endfunction

endpackage

// File: rtl/conversor_bcd_ajuste.sv
// -----------------------------------------------------------------------------
// ajuste_bcd
//
// Combinational add-3 correction for one BCD nibble in the double-dabble
// algorithm: a nibble of 5 or more gets 3 added so that the following left
// shift carries correctly into the next decimal digit.
//
// Ports:
//   digito    in  [3:0]  BCD nibble before correction
//   corrigido out [3:0]  nibble after the conditional +3
// -----------------------------------------------------------------------------
module ajuste_bcd (
    input  logic [3:0] digito,
    output logic [3:0] corrigido
);

    always_comb begin
        if (digito >= 4'd5) begin
            corrigido = digito + 4'd3;
        end else begin
            corrigido = digito;
        end
    end

endmodule

// File: rtl/conversor_bcd.sv
// -----------------------------------------------------------------------------
// conversor_bcd
//
// Converts an 8-bit signed value into a sign flag plus two BCD digits for a
// double-digit 7-segment display. Conversion uses a sequential double-dabble
// over the low 7 magnitude bits, one iteration per clock, giving a fixed
// latency of 8 edges from the accepted start request to the pronto pulse.
// Magnitudes above 99 (including -128) show dashes on both digits.
//
// Handshake: inicio is a request sampled on a rising edge only while idle
// (ocupado=0); it is ignored otherwise. entrada is captured on that same
// edge. ocupado is high from the accepting edge until the result edge, and
// pronto pulses for exactly one cycle as the new results appear. Since the
// FSM is already idle during the pronto cycle, a request held in that cycle
// is accepted, so back-to-back conversions complete every 9 cycles.
//
// Ports:
//   clock    in        rising-edge clock
//   reset    in        asynchronous active-high reset
//   inicio   in        start request
//   entrada  in  [7:0] signed two's-complement value to convert
//   ocupado  out       conversion in progress
//   pronto   out       one-cycle pulse, results valid
//   sinal    out       negative flag for the display sign input
//   dezena   out [3:0] tens digit or display code
//   unidade  out [3:0] units digit or display code
//   estado   out       current FSM state, for observation
//
// Configuration macro: CONVERSOR_BCD_ZERO_BLANK_EN
//   defined   -> a tens digit of 0 is shown as blank (DIGITO_APAGADO)
//   undefined -> the tens digit is always the true digit (or dash)
// -----------------------------------------------------------------------------
module conversor_bcd
    import conversor_bcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inicio,
    input  logic [7:0] entrada,
    output logic       ocupado,
    output logic       pronto,
    output logic       sinal,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output estado_t    estado
);

    // Shift register layout: [14:11] tens, [10:7] units, [6:0] binary bits
    // still to be shifted in.
    localparam int LARGURA_DESLOC = 15;

    logic [LARGURA_DESLOC-1:0] desloc;
    logic [LARGURA_DESLOC-1:0] desloc_prox;
    logic [2:0]                contador;
    logic                      sinal_cap;
    logic                      estouro_cap;

    logic [7:0]                modulo;
    logic [3:0]                dezena_ajust;
    logic [3:0]                unidade_ajust;
    logic [3:0]                dezena_final;
    logic [3:0]                unidade_final;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    assign modulo = modulo_de(entrada);

    ajuste_bcd u_ajuste_dezena (
        .digito    (desloc[14:11]),
        .corrigido (dezena_ajust)
    );

    ajuste_bcd u_ajuste_unidade (
        .digito    (desloc[10:7]),
        .corrigido (unidade_ajust)
    );

    // Correct both nibbles, then shift the whole register left by one.
    assign desloc_prox = {dezena_ajust[2:0], unidade_ajust, desloc[6:0], 1'b0};

    // Display codes presented at the result edge.
    always_comb begin
        dezena_final  = desloc[14:11];
        unidade_final = desloc[10:7];
        if (estouro_cap) begin
            dezena_final  = DIGITO_TRACO;
            unidade_final = DIGITO_TRACO;
        end else begin
`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
            if (desloc[14:11] == 4'd0) begin
                dezena_final = DIGITO_APAGADO;
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
            sinal       <= 1'b0;
            dezena      <= 4'h0;
            unidade     <= 4'h0;
            desloc      <= '0;
            contador    <= 3'd0;
            sinal_cap   <= 1'b0;
            estouro_cap <= 1'b0;
        end else begin
            pronto <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        sinal_cap   <= entrada[7];
                        estouro_cap <= (modulo > LIMITE_DISPLAY);
                        // Only the low 7 bits are converted; anything that
                        // needs bit 7 is an overflow and shows dashes.
                        desloc      <= {8'd0, modulo[6:0]};
                        contador    <= 3'd0;
                        ocupado     <= 1'b1;
                        estado      <= CONVERTE;
                    end
                end

                CONVERTE: begin
                    desloc   <= desloc_prox;
                    contador <= contador + 3'd1;
                    if (contador == 3'(N_ITERACOES - 1)) begin
                        estado <= FIM;
                    end
                end

                FIM: begin
                    sinal   <= sinal_cap;
                    dezena  <= dezena_final;
                    unidade <= unidade_final;
                    pronto  <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end

                default: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd.sv
// -----------------------------------------------------------------------------
// tb_conversor_bcd
//
// Directed bench for conversor_bcd: reset values, signed conversions with
// hand-computed digits, overflow cases, latency/busy length, pulse width,
// back-to-back spacing with inicio held high, and reset mid-conversion.
// -----------------------------------------------------------------------------
module tb_conversor_bcd;
    import conversor_bcd_pkg::*;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       inicio  = 1'b0;
    logic [7:0] entrada = 8'd0;
    logic       ocupado;
    logic       pronto;
    logic       sinal;
    logic [3:0] dezena;
    logic [3:0] unidade;
    estado_t    estado;

    always #5 clock = ~clock;

    conversor_bcd dut (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio),
        .entrada (entrada),
        .ocupado (ocupado),
        .pronto  (pronto),
        .sinal   (sinal),
        .dezena  (dezena),
        .unidade (unidade),
        .estado  (estado)
    );

`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
    localparam logic [3:0] DEZ_ZERO = 4'hA;
`else
    localparam logic [3:0] DEZ_ZERO = 4'h0;
`endif

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int         n_comp = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_comp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_result(input string tag);
        logic [8:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 16'd1, 16'd0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, {7'd0, sinal, dezena, unidade}, {7'd0, exp});
        end
    endtask

    // Waits for pronto after the accepting edge; returns edges elapsed and the
    // number of those cycles in which ocupado was high before pronto.
    task automatic wait_pronto(output int cycles, output int busy);
        cycles = 0;
        busy   = 0;
        while (pronto !== 1'b1 && cycles < 20) begin
            @(posedge clock);
            #1;
            cycles++;
            if (pronto !== 1'b1 && ocupado === 1'b1) busy++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver
    // -------------------------------------------------------------------------
    task automatic do_conv(input logic [7:0] val, input logic s,
                           input logic [3:0] d, input logic [3:0] u);
        int    cycles;
        int    busy;
        string tag;
        logic  first_busy;
        tag = $sformatf("conv_%02h", val);
        @(negedge clock);
        entrada = val;
        inicio  = 1'b1;
        exp_q.push_back({s, d, u});
        @(posedge clock);
        #1;
        inicio     = 1'b0;
        entrada    = ~val;   // must not disturb the captured value
        first_busy = ocupado;
        wait_pronto(cycles, busy);
        check({tag, "_latency"}, 16'(cycles), 16'd8);
        check({tag, "_ocupado_len"}, 16'(busy + int'(first_busy)), 16'd8);
        compare_result(tag);
        check({tag, "_ocupado_at_pronto"}, {15'd0, ocupado}, 16'd0);
        @(posedge clock);
        #1;
        check({tag, "_pronto_pulse"}, {15'd0, pronto}, 16'd0);
        check({tag, "_hold"}, {7'd0, sinal, dezena, unidade}, {7'd0, s, d, u});
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int cycles;
        int busy;
        int pronto_seen;

        #3 reset = 1'b1;
        #1;
        check("rst_ocupado", {15'd0, ocupado}, 16'd0);
        check("rst_pronto", {15'd0, pronto}, 16'd0);
        check("rst_outputs", {7'd0, sinal, dezena, unidade}, 16'd0);
        check("rst_estado", {14'd0, estado}, {14'd0, OCIOSO});
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Directed vectors: value, sinal, dezena, unidade
        do_conv(8'h39, 1'b0, 4'h5, 4'h7);       //   57
        do_conv(8'hD6, 1'b1, 4'h4, 4'h2);       //  -42
        do_conv(8'h9D, 1'b1, 4'h9, 4'h9);       //  -99
        do_conv(8'h64, 1'b0, 4'hF, 4'hF);       //  100 overflow
        do_conv(8'h80, 1'b1, 4'hF, 4'hF);       // -128 overflow
        do_conv(8'h00, 1'b0, DEZ_ZERO, 4'h0);   //    0
        do_conv(8'h63, 1'b0, 4'h9, 4'h9);       //   99
        do_conv(8'hFF, 1'b1, DEZ_ZERO, 4'h1);   //   -1
        do_conv(8'h7F, 1'b0, 4'hF, 4'hF);       //  127 overflow
        do_conv(8'h0A, 1'b0, 4'h1, 4'h0);       //   10

        // Back-to-back with inicio held high; second value sampled only
        // once the first conversion finishes.
        @(negedge clock);
        entrada = 8'd57;
        inicio  = 1'b1;
        exp_q.push_back({1'b0, 4'h5, 4'h7});
        @(posedge clock);
        #1;
        entrada = 8'd12;
        wait_pronto(cycles, busy);
        check("b2b_first_latency", 16'(cycles), 16'd8);
        compare_result("b2b_first");
        exp_q.push_back({1'b0, 4'h1, 4'h2});
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
            if (cycles == 1) begin
                check("b2b_accepted", {15'd0, ocupado}, 16'd1);
                inicio = 1'b0;
            end
        end while (pronto !== 1'b1 && cycles < 20);
        check("b2b_spacing", 16'(cycles), 16'd9);
        compare_result("b2b_second");

        // Reset in the 4th CONVERTE cycle discards the conversion.
        repeat (2) @(posedge clock);
        @(negedge clock);
        entrada = 8'd57;
        inicio  = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {7'd0, sinal, dezena, unidade}, 16'd0);
        check("midrst_ocupado", {15'd0, ocupado}, 16'd0);
        check("midrst_estado", {14'd0, estado}, {14'd0, OCIOSO});
        @(negedge clock);
        reset = 1'b0;
        pronto_seen = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (pronto === 1'b1) pronto_seen++;
        end
        check("midrst_no_pronto", 16'(pronto_seen), 16'd0);
        do_conv(8'h07, 1'b0, DEZ_ZERO, 4'h7);

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: inicio  input  1  start request, sampled on rising clock edge while idle.
REQ-004 SHALL have port: entrada  input  8  signed two's-complement value to convert (-128..127).
REQ-005 SHALL have port: ocupado  output  1  high while a conversion is in progress.
REQ-006 SHALL have port: pronto  output  1  one-cycle pulse when new results are valid.
REQ-007 SHALL have port: sinal  output  1  negative flag feeding the double-digit display sign input.
REQ-008 SHALL have port: dezena  output  4  tens BCD digit or display code.
REQ-009 SHALL have port: unidade  output  4  units BCD digit or display code.
REQ-010 SHALL use display codes: 4'hF = dash, 4'hA = blank, 4'h0..4'h9 = digits.

Function
REQ-011 SHALL implement FSM states OCIOSO, CONVERTE and FIM.
REQ-012 In OCIOSO with inicio=1 at edge N, SHALL capture sign = entrada[7] and magnitude = |entrada| as an 8-bit unsigned value, clear the iteration counter, and enter CONVERTE.
REQ-013 SHALL flag overflow at capture when magnitude > 99, including -128 (magnitude 128).
REQ-014 In CONVERTE, SHALL perform one double-dabble iteration per edge (add 3 to each BCD nibble >= 5, then shift left one bit) over the low 7 magnitude bits, for exactly 7 iterations (edges N+1..N+7), then enter FIM.
REQ-015 In FIM (edge N+8), SHALL register sinal, dezena and unidade, assert pronto for that following cycle only, and return to OCIOSO.
REQ-016 Latency SHALL be fixed at 8 edges from accepting inicio to pronto high, overflow included.
REQ-017 On overflow, SHALL output dezena = unidade = 4'hF and sinal = captured sign.
REQ-018 Input 0 SHALL give sinal=0, dezena=0, unidade=0; sinal SHALL be 1 only for negative inputs.
REQ-019 ocupado SHALL be 1 in CONVERTE and FIM and 0 in OCIOSO.
REQ-020 inicio while ocupado=1 SHALL be ignored; entrada changes after capture SHALL NOT affect the result.
REQ-021 inicio in the cycle pronto=1 SHALL be accepted, because the state is OCIOSO in that cycle.
REQ-022 sinal, dezena and unidade SHALL hold their last values until the next FIM; they SHALL never show intermediate shift values.

Reset
REQ-023 reset=1 SHALL asynchronously force: state OCIOSO, ocupado=0, pronto=0, sinal=0, dezena=4'h0, unidade=4'h0, internal shift register and counter cleared.
REQ-024 reset asserted mid-conversion SHALL discard the conversion with no pronto pulse; the first inicio after release SHALL start a full 8-edge conversion.

Configuration
REQ-025 Macro CONVERSOR_BCD_ZERO_BLANK_EN defined: in FIM, a non-overflow result with tens digit 0 SHALL output dezena = 4'hA (blank).
REQ-026 Macro CONVERSOR_BCD_ZERO_BLANK_EN undefined: dezena SHALL always be the true tens digit (0..9) or 4'hF on overflow; reset values and timing are unchanged in both builds.

Structure
REQ-027 The shared package conversor_bcd_pkg SHALL hold the state encodings, DIGITO_TRACO=4'hF, DIGITO_APAGADO=4'hA and LIMITE_DISPLAY=99.
REQ-028 The combinational add-3 nibble correction SHALL be one sub-module, ajuste_bcd (4-bit in, 4-bit out), instantiated once per BCD nibble.
REQ-029 The block SHALL contain no display decoding; its outputs connect directly to the double-digit 7-segment decoder.

Verification
REQ-030 entrada=8'h39 (57), inicio pulse -> after 8 edges pronto=1 for one cycle, sinal=0, dezena=5, unidade=7; ocupado=1 for 8 cycles.
REQ-031 entrada=8'hD6 (-42) -> sinal=1, dezena=4, unidade=2; entrada=8'h9D (-99) -> sinal=1, dezena=9, unidade=9.
REQ-032 entrada=8'h64 (100) -> sinal=0, dezena=unidade=4'hF; entrada=8'h80 (-128) -> sinal=1, dezena=unidade=4'hF; latency 8 in both cases.
REQ-033 inicio held high continuously with entrada changing -> second input ignored until pronto; back-to-back conversions have pronto spaced every 9 cycles.
REQ-034 reset asserted at the 4th CONVERTE cycle -> immediate outputs 0/0/0, no pronto; next conversion of 8'h07 -> dezena=0 (macro off) or 4'hA (macro on), unidade=7.
